// File: rtl/sr_cmd_gen.sv
// Command stage for the SR flip-flop: sync, debounce and arbitrate set/clear requests
// into mutually exclusive one-cycle s/r pulses. Define SR_CONFLICT_CNT_EN to add conflict_cnt.
module sr_cmd_gen #(
   parameter int DEB_CYCLES     = 4,
   parameter int LOCKOUT_CYCLES = 2,
   parameter bit RESET_PRIORITY = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       set_raw,
   input  logic       clr_raw,
   output logic       s,
   output logic       r,
   output logic       conflict,
   output logic       busy
`ifdef SR_CONFLICT_CNT_EN
   ,
   output logic [7:0] conflict_cnt
`endif
);

   localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam int LK_W  = $clog2(LOCKOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

   typedef enum logic {IDLE = 1'b0, LOCKOUT = 1'b1} state_t;

   // Channel index 0 = set, 1 = clear
   logic [1:0]       raw;
   logic [1:0]       sync_p0, sync_p1;
   logic [1:0]       stb, pend, rise;
   logic [CNT_W-1:0] deb_cnt [2];
   state_t           state, state_nxt;
   logic [LK_W-1:0]  lk_cnt;
   logic             s_nxt, r_nxt, conflict_nxt;

   assign raw = {clr_raw, set_raw};

   // Stage p0/p1: two-flop synchroniser
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
      end
   end

   always_comb begin
      rise = '0;
      for (int i = 0; i < 2; i++)
         rise[i] = sync_p1[i] && !stb[i] && (deb_cnt[i] == DEB_LAST);
   end

   // Debounce: stable level follows only after DEB_CYCLES consecutive mismatches
   always_ff @(posedge clk) begin
      if (reset) begin
         stb <= '0;
         for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync_p1[i] == stb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               stb[i]     <= sync_p1[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Every IDLE cycle consumes all pending flags (winner issued, loser dropped);
   // a rise on the same edge still lands.
   always_ff @(posedge clk) begin
      if (reset) pend <= '0;
      else       pend <= rise | (pend & ~{2{state == IDLE}});
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|pend) state_nxt = LOCKOUT;
         LOCKOUT: if (lk_cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_nxt        = 1'b0;
      r_nxt        = 1'b0;
      conflict_nxt = 1'b0;
      if (state == IDLE) begin
         if (pend == 2'b11) begin
            conflict_nxt = 1'b1;
            r_nxt        = RESET_PRIORITY;
            s_nxt        = !RESET_PRIORITY;
         end else begin
            s_nxt = pend[0];
            r_nxt = pend[1];
         end
      end
   end

   // Stage p2: registered command outputs and lockout timer
   always_ff @(posedge clk) begin
      if (reset) begin
         s        <= 1'b0;
         r        <= 1'b0;
         conflict <= 1'b0;
         lk_cnt   <= '0;
      end else begin
         s        <= s_nxt;
         r        <= r_nxt;
         conflict <= conflict_nxt;
         if (state == IDLE)     lk_cnt <= LK_W'(LOCKOUT_CYCLES);
         else if (lk_cnt != '0) lk_cnt <= lk_cnt - LK_W'(1);
      end
   end

   // The first LOCKOUT cycle carries the command pulse itself, so busy covers
   // only the LOCKOUT_CYCLES cycles that follow it.
   assign busy = (state == LOCKOUT) && !(s || r);

`ifdef SR_CONFLICT_CNT_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset)         conflict_cnt <= '0;
      else if (conflict) conflict_cnt <= sat_inc8(conflict_cnt);
   end
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen: expected commands are queued at stimulus time and
// matched (value and cycle) by a negedge monitor that also checks the invariants.
module tb_sr_cmd_gen;

   localparam int DEB = 4;
   localparam int LK  = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic set_raw = 1'b0;
   logic clr_raw = 1'b0;
   logic s, r, conflict, busy;
`ifdef SR_CONFLICT_CNT_EN
   logic [7:0] conflict_cnt;
`endif

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int busy_run = 0;

   typedef struct {
      logic s;
      logic r;
      logic c;
      int   at;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;

   sr_cmd_gen #(
      .DEB_CYCLES     (DEB),
      .LOCKOUT_CYCLES (LK),
      .RESET_PRIORITY (1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .set_raw      (set_raw),
      .clr_raw      (clr_raw),
      .s            (s),
      .r            (r),
      .conflict     (conflict),
      .busy         (busy)
`ifdef SR_CONFLICT_CNT_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset) begin
         busy_run = 0;
      end else begin
         checks++;
         assert (!(s && r)) else begin
            errors++;
            $error("FAIL s_and_r cyc=%0d observed s=%0b r=%0b expected not both high", cyc, s, r);
         end
         checks++;
         assert (!(busy && (s || r))) else begin
            errors++;
            $error("FAIL cmd_while_busy cyc=%0d observed busy=%0b s=%0b r=%0b expected no command", cyc, busy, s, r);
         end
         if (busy) begin
            busy_run++;
         end else if (busy_run != 0) begin
            checks++;
            assert (busy_run == LK) else begin
               errors++;
               $error("FAIL busy_width cyc=%0d observed %0d expected %0d", cyc, busy_run, LK);
            end
            busy_run = 0;
         end
         if (s || r || conflict) begin
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_cmd cyc=%0d observed s=%0b r=%0b conflict=%0b expected none", cyc, s, r, conflict);
            end
            if (sb.size() != 0) begin
               e_mon = sb.pop_front();
               checks++;
               assert ({s, r, conflict} === {e_mon.s, e_mon.r, e_mon.c}) else begin
                  errors++;
                  $error("FAIL cmd_value cyc=%0d observed src=%b expected src=%b", cyc, {s, r, conflict}, {e_mon.s, e_mon.r, e_mon.c});
               end
               checks++;
               assert (cyc == e_mon.at) else begin
                  errors++;
                  $error("FAIL cmd_cycle observed %0d expected %0d", cyc, e_mon.at);
               end
            end
         end
      end
   end

   task automatic expect_cmd(input logic es, input logic er, input logic ec, input int at);
      exp_t e;
      e.s  = es;
      e.r  = er;
      e.c  = ec;
      e.at = at;
      sb.push_back(e);
   endtask

   task automatic at_cyc(input int t);
      while (cyc < t) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   initial begin
      int t0;
      int ec;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_s", s, 0);
      chk("rst_r", r, 0);
      chk("rst_conflict", conflict, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      at_cyc(cyc + 3);

      // clean set: first sampled at t0+1, s after edge t0+1+DEB+2
      t0 = cyc;
      set_raw = 1'b1;
      expect_cmd(1'b1, 1'b0, 1'b0, t0 + DEB + 3);
      at_cyc(t0 + DEB + 3);
      chk("clean_s", s, 1);
      chk("clean_r", r, 0);
      at_cyc(t0 + DEB + 4);
      chk("clean_busy", busy, 1);
      chk("clean_s_off", s, 0);
      set_raw = 1'b0;
      at_cyc(t0 + 40);

      // bounce: pulses of 1 and 3 cycles never reach DEB
      t0 = cyc;
      set_raw = 1'b1;
      at_cyc(t0 + 1);
      set_raw = 1'b0;
      at_cyc(t0 + 3);
      set_raw = 1'b1;
      at_cyc(t0 + 6);
      set_raw = 1'b0;
      at_cyc(t0 + 30);
      chk("bounce_idle", busy, 0);

      // simultaneous requests: reset priority wins with conflict
      t0 = cyc;
      set_raw = 1'b1;
      clr_raw = 1'b1;
      expect_cmd(1'b0, 1'b1, 1'b1, t0 + DEB + 3);
      at_cyc(t0 + DEB + 3);
      chk("simul_r", r, 1);
      chk("simul_conflict", conflict, 1);
      chk("simul_s", s, 0);
      at_cyc(t0 + DEB + 4);
      set_raw = 1'b0;
      clr_raw = 1'b0;
      at_cyc(t0 + 40);

      // clear request lands during lockout of a set command
      t0 = cyc;
      ec = t0 + DEB + 3;
      set_raw = 1'b1;
      expect_cmd(1'b1, 1'b0, 1'b0, ec);
      at_cyc(t0 + 3);
      clr_raw = 1'b1;
      expect_cmd(1'b0, 1'b1, 1'b0, ec + LK + 2);
      at_cyc(ec + 2);
      chk("lk_busy", busy, 1);
      at_cyc(ec + LK + 1);
      chk("lk_busy_fell", busy, 0);
      at_cyc(ec + LK + 2);
      chk("lk_r", r, 1);
      set_raw = 1'b0;
      clr_raw = 1'b0;
      at_cyc(cyc + 40);

      // both channels become pending during lockout
      t0 = cyc;
      ec = t0 + DEB + 3;
      clr_raw = 1'b1;
      expect_cmd(1'b0, 1'b1, 1'b0, ec);
      at_cyc(t0 + 1);
      set_raw = 1'b1;
      at_cyc(t0 + DEB);
      clr_raw = 1'b0;
      at_cyc(t0 + 2 * DEB);
      clr_raw = 1'b1;
      expect_cmd(1'b0, 1'b1, 1'b1, ec + LK + 2);
      at_cyc(ec + LK + 2);
      chk("lk2_conflict", conflict, 1);
      chk("lk2_s", s, 0);
      set_raw = 1'b0;
      clr_raw = 1'b0;
      at_cyc(cyc + 40);

      // reset mid-lockout with set pending, set_raw held through reset
      t0 = cyc;
      ec = t0 + DEB + 3;
      clr_raw = 1'b1;
      expect_cmd(1'b0, 1'b1, 1'b0, ec);
      at_cyc(t0 + 1);
      set_raw = 1'b1;
      at_cyc(t0 + DEB);
      clr_raw = 1'b0;
      at_cyc(ec + 2);
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      at_cyc(ec + 3);
      chk("mid_rst_s", s, 0);
      chk("mid_rst_r", r, 0);
      chk("mid_rst_conflict", conflict, 0);
      chk("mid_rst_busy", busy, 0);
      reset = 1'b0;
      expect_cmd(1'b1, 1'b0, 1'b0, ec + DEB + 6);
      at_cyc(ec + DEB + 6);
      chk("post_rst_s", s, 1);
      set_raw = 1'b0;
      at_cyc(cyc + 40);

`ifdef SR_CONFLICT_CNT_EN
      chk("ccnt_start", conflict_cnt, 0);
      for (int i = 0; i < 257; i++) begin
         t0 = cyc;
         set_raw = 1'b1;
         clr_raw = 1'b1;
         expect_cmd(1'b0, 1'b1, 1'b1, t0 + DEB + 3);
         at_cyc(t0 + DEB + 4);
         set_raw = 1'b0;
         clr_raw = 1'b0;
         if (i == 0) chk("ccnt_one", conflict_cnt, 1);
         at_cyc(t0 + 30);
      end
      chk("ccnt_sat", conflict_cnt, 255);
      reset = 1'b1;
      at_cyc(cyc + 1);
      chk("ccnt_rst", conflict_cnt, 0);
      reset = 1'b0;
      at_cyc(cyc + 3);
`endif

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
